// File: rtl/waveform_pkg.sv
// rtl/waveform_pkg.sv - shared enums for the programmable waveform generator
package waveform_pkg;

    typedef enum logic [1:0] {
        SAW_UP   = 2'd0,
        SAW_DOWN = 2'd1,
        TRIANGLE = 2'd2,
        SQUARE   = 2'd3
    } mode_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } state_t;

endpackage

// File: rtl/waveform_generator.sv
// rtl/waveform_generator.sv - programmable sawtooth/triangle/square generator between lo..hi
module waveform_generator
    import waveform_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         cfg_load,
    input  mode_t        mode_in,
    input  logic [N-1:0] lo_in,
    input  logic [N-1:0] hi_in,
    input  logic [N-1:0] step_in,
    output logic [N-1:0] out,
    output logic         dir,
    output logic         period,
    output logic         cfg_err
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    mode_t        r_mode;
    logic [N-1:0] r_lo;
    logic [N-1:0] r_hi;
    logic [N-1:0] r_step;
    logic [N-1:0] r_out;
    state_t       r_dir;
    logic         r_period;
    logic         r_cfg_err;
    logic [N-1:0] r_cnt;

    // Sums are one bit wider so wrap/clamp decisions never see modular overflow.
    logic [N:0]   w_up_sum;
    logic [N:0]   w_lo_plus_step;
    logic [N-1:0] w_down_diff;
    logic         w_step_zero;
    logic [N-1:0] w_sq_half;
    logic         w_sq_last;

    assign w_up_sum       = {1'b0, r_out} + {1'b0, r_step};
    assign w_lo_plus_step = {1'b0, r_lo} + {1'b0, r_step};
    assign w_down_diff    = r_out - r_step;
    assign w_step_zero    = (r_step == '0);
    assign w_sq_half      = w_step_zero ? ONE : r_step;
    assign w_sq_last      = (r_cnt == (w_sq_half - ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode    <= SAW_UP;
            r_lo      <= '0;
            r_hi      <= '1;
            r_step    <= ONE;
            r_out     <= '0;
            r_dir     <= UP;
            r_period  <= 1'b0;
            r_cfg_err <= 1'b0;
            r_cnt     <= '0;
        end else if (cfg_load) begin
            r_mode    <= mode_in;
            r_lo      <= lo_in;
            r_hi      <= hi_in;
            r_step    <= step_in;
            r_out     <= lo_in;
            r_dir     <= UP;
            r_period  <= 1'b0;
            r_cfg_err <= (lo_in >= hi_in);
            r_cnt     <= '0;
        end else begin
            r_period <= 1'b0;
            if (ena && !r_cfg_err) begin
                case (r_mode)
                    SAW_UP: begin
                        r_dir <= UP;
                        if (!w_step_zero) begin
                            if (w_up_sum > {1'b0, r_hi}) begin
                                r_out    <= r_lo;
                                r_period <= 1'b1;
                            end else begin
                                r_out <= w_up_sum[N-1:0];
                            end
                        end
                    end
                    SAW_DOWN: begin
                        r_dir <= DOWN;
                        if (!w_step_zero) begin
                            if ({1'b0, r_out} < w_lo_plus_step) begin
                                r_out    <= r_hi;
                                r_period <= 1'b1;
                            end else begin
                                r_out <= w_down_diff;
                            end
                        end
                    end
                    TRIANGLE: begin
                        // Endpoints clamp exactly so a non-dividing step never overshoots.
                        if (!w_step_zero) begin
                            if (r_dir == UP) begin
                                if (w_up_sum >= {1'b0, r_hi}) begin
                                    r_out <= r_hi;
                                    r_dir <= DOWN;
                                end else begin
                                    r_out <= w_up_sum[N-1:0];
                                end
                            end else begin
                                if ({1'b0, r_out} <= w_lo_plus_step) begin
                                    r_out    <= r_lo;
                                    r_dir    <= UP;
                                    r_period <= 1'b1;
                                end else begin
                                    r_out <= w_down_diff;
                                end
                            end
                        end
                    end
                    SQUARE: begin
                        if (w_sq_last) begin
                            r_cnt <= '0;
                            if (r_dir == UP) begin
                                r_dir    <= DOWN;
                                r_out    <= r_hi;
                                r_period <= 1'b1;
                            end else begin
                                r_dir <= UP;
                                r_out <= r_lo;
                            end
                        end else begin
                            r_cnt <= r_cnt + ONE;
                        end
                    end
                endcase
            end
        end
    end

    assign out     = r_out;
    assign dir     = (r_dir == DOWN);
    assign period  = r_period;
    assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_waveform_generator.sv
// tb/tb_waveform_generator.sv - directed scoreboard bench for waveform_generator
module tb_waveform_generator;
    import waveform_pkg::*;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       cfg_load;
    mode_t      mode_in;
    logic [7:0] lo_in;
    logic [7:0] hi_in;
    logic [7:0] step_in;
    logic [7:0] out;
    logic       dir;
    logic       period;
    logic       cfg_err;

    typedef struct {
        logic [7:0] o;
        logic       d;
        logic       p;
        logic       e;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    waveform_generator #(.N(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .cfg_load (cfg_load),
        .mode_in  (mode_in),
        .lo_in    (lo_in),
        .hi_in    (hi_in),
        .step_in  (step_in),
        .out      (out),
        .dir      (dir),
        .period   (period),
        .cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic e, input logic [7:0] xo, input logic xd,
                       input logic xp, input logic xe, input string tag);
        exp_t x;
        exp_t got;
        ena  = e;
        x.o  = xo;
        x.d  = xd;
        x.p  = xp;
        x.e  = xe;
        x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checks++;
        assert (out === got.o) else begin
            failures++;
            $error("FAIL %s out: got %0d expected %0d", got.tag, out, got.o);
        end
        checks++;
        assert (dir === got.d) else begin
            failures++;
            $error("FAIL %s dir: got %0b expected %0b", got.tag, dir, got.d);
        end
        checks++;
        assert (period === got.p) else begin
            failures++;
            $error("FAIL %s period: got %0b expected %0b", got.tag, period, got.p);
        end
        checks++;
        assert (cfg_err === got.e) else begin
            failures++;
            $error("FAIL %s cfg_err: got %0b expected %0b", got.tag, cfg_err, got.e);
        end
    endtask

    // Loads a config, then scrambles the config inputs to prove they are only sampled on cfg_load.
    task automatic load(input mode_t m, input logic [7:0] l, input logic [7:0] h,
                        input logic [7:0] s, input logic e, input logic xe, input string tag);
        mode_in  = m;
        lo_in    = l;
        hi_in    = h;
        step_in  = s;
        cfg_load = 1'b1;
        cyc(e, l, 1'b0, 1'b0, xe, tag);
        cfg_load = 1'b0;
        mode_in  = mode_t'(~m);
        lo_in    = 8'hA5;
        hi_in    = 8'h11;
        step_in  = 8'h77;
    endtask

    initial begin
        rst      = 1'b1;
        ena      = 1'b0;
        cfg_load = 1'b0;
        mode_in  = SQUARE;
        lo_in    = 8'd7;
        hi_in    = 8'd3;
        step_in  = 8'd9;
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "reset");
        cyc(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "reset_ena");
        rst = 1'b0;

        // Default SAW_UP 0..255 full wrap.
        for (int k = 1; k <= 256; k++) begin
            logic [7:0] xo;
            xo = 8'(k);
            cyc(1'b1, xo, 1'b0, (k == 256), 1'b0, "saw_up_default");
        end
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "hold_ena0");

        // Triangle with non-dividing step; ena high during load must be ignored.
        load(TRIANGLE, 8'd10, 8'd20, 8'd3, 1'b1, 1'b0, "tri_load");
        cyc(1'b1, 8'd13, 1'b0, 1'b0, 1'b0, "tri_13");
        cyc(1'b1, 8'd16, 1'b0, 1'b0, 1'b0, "tri_16");
        cyc(1'b1, 8'd19, 1'b0, 1'b0, 1'b0, "tri_19");
        cyc(1'b1, 8'd20, 1'b1, 1'b0, 1'b0, "tri_hi");
        cyc(1'b1, 8'd17, 1'b1, 1'b0, 1'b0, "tri_17");
        cyc(1'b1, 8'd14, 1'b1, 1'b0, 1'b0, "tri_14");
        cyc(1'b1, 8'd11, 1'b1, 1'b0, 1'b0, "tri_11");
        cyc(1'b1, 8'd10, 1'b0, 1'b1, 1'b0, "tri_lo");
        cyc(1'b1, 8'd13, 1'b0, 1'b0, 1'b0, "tri_13b");

        // SAW_DOWN with ena toggling.
        load(SAW_DOWN, 8'd0, 8'd100, 8'd30, 1'b0, 1'b0, "sd_load");
        cyc(1'b1, 8'd100, 1'b1, 1'b1, 1'b0, "sd_100");
        cyc(1'b0, 8'd100, 1'b1, 1'b0, 1'b0, "sd_100h");
        cyc(1'b1, 8'd70,  1'b1, 1'b0, 1'b0, "sd_70");
        cyc(1'b0, 8'd70,  1'b1, 1'b0, 1'b0, "sd_70h");
        cyc(1'b1, 8'd40,  1'b1, 1'b0, 1'b0, "sd_40");
        cyc(1'b0, 8'd40,  1'b1, 1'b0, 1'b0, "sd_40h");
        cyc(1'b1, 8'd10,  1'b1, 1'b0, 1'b0, "sd_10");
        cyc(1'b0, 8'd10,  1'b1, 1'b0, 1'b0, "sd_10h");
        cyc(1'b1, 8'd100, 1'b1, 1'b1, 1'b0, "sd_wrap");
        cyc(1'b0, 8'd100, 1'b1, 1'b0, 1'b0, "sd_wraph");

        // SQUARE half-period 2.
        load(SQUARE, 8'd5, 8'd200, 8'd2, 1'b1, 1'b0, "sq_load");
        cyc(1'b1, 8'd5,   1'b0, 1'b0, 1'b0, "sq_lo1");
        cyc(1'b1, 8'd200, 1'b1, 1'b1, 1'b0, "sq_hi0");
        cyc(1'b1, 8'd200, 1'b1, 1'b0, 1'b0, "sq_hi1");
        cyc(1'b1, 8'd5,   1'b0, 1'b0, 1'b0, "sq_lo0");
        cyc(1'b1, 8'd5,   1'b0, 1'b0, 1'b0, "sq_lo1b");
        cyc(1'b1, 8'd200, 1'b1, 1'b1, 1'b0, "sq_hi0b");

        // SQUARE with step=0 behaves as half-period 1.
        load(SQUARE, 8'd1, 8'd2, 8'd0, 1'b0, 1'b0, "sq0_load");
        cyc(1'b1, 8'd2, 1'b1, 1'b1, 1'b0, "sq0_hi");
        cyc(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, "sq0_lo");
        cyc(1'b1, 8'd2, 1'b1, 1'b1, 1'b0, "sq0_hi2");

        // Invalid config lo == hi holds lo.
        load(SAW_UP, 8'd50, 8'd50, 8'd1, 1'b0, 1'b1, "err_load");
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 8'd50, 1'b0, 1'b0, 1'b1, "err_hold");
        end
        load(TRIANGLE, 8'd9, 8'd3, 8'd1, 1'b0, 1'b1, "err_lo_gt_hi");
        cyc(1'b1, 8'd9, 1'b0, 1'b0, 1'b1, "err_lo_gt_hi_hold");

        // Recovery with small range; hi is inclusive.
        load(SAW_UP, 8'd0, 8'd9, 8'd1, 1'b0, 1'b0, "rec_load");
        for (int k = 1; k <= 10; k++) begin
            logic [7:0] xo;
            xo = 8'(k % 10);
            cyc(1'b1, xo, 1'b0, (k == 10), 1'b0, "rec_ramp");
        end

        // Ramp step=0 holds with no period pulses.
        load(SAW_UP, 8'd3, 8'd9, 8'd0, 1'b0, 1'b0, "st0_load");
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, "st0_hold");
        end

        // rst beats cfg_load mid-triangle.
        load(TRIANGLE, 8'd10, 8'd20, 8'd3, 1'b0, 1'b0, "rc_load");
        cyc(1'b1, 8'd13, 1'b0, 1'b0, 1'b0, "rc_13");
        cyc(1'b1, 8'd16, 1'b0, 1'b0, 1'b0, "rc_16");
        mode_in  = SQUARE;
        lo_in    = 8'd40;
        hi_in    = 8'd90;
        step_in  = 8'd4;
        rst      = 1'b1;
        cfg_load = 1'b1;
        cyc(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "rst_wins");
        rst      = 1'b0;
        cfg_load = 1'b0;
        cyc(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, "post_rst_sawup");
        cyc(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, "post_rst_sawup2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
